// File: rtl/noc_xbar_switch.sv
// noc_xbar_switch: registered NoC crossbar. Each output runs round-robin arbitration with
// wormhole locking; heads with an out-of-range destination are drained and counted.

module noc_xbar_out_port #(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = 16,
    parameter int PW        = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0][FLIT_W-1:0] in_flit,
    input  logic [NUM_PORTS-1:0]             in_tail,
    input  logic                             out_ready,
    output logic [NUM_PORTS-1:0]             gnt,
    output logic                             locked,
    output logic [PW-1:0]                    owner,
    output logic [FLIT_W-1:0]                out_flit,
    output logic                             out_tail,
    output logic                             out_valid
);
    logic [PW-1:0] rr_ptr, win, win_nxt;
    logic          found, ld, xfer;

    // While locked only the owner raises req, so the same search yields the owner.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_PORTS;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign win_nxt = (win == PW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
    assign ld      = !out_valid || out_ready;
    assign xfer    = found && ld;
    assign gnt     = xfer ? (NUM_PORTS'(1) << win) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_tail  <= 1'b0;
            locked    <= 1'b0;
            owner     <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_flit  <= in_flit[win];
            out_tail  <= in_tail[win];
            if (in_tail[win]) begin
                locked <= 1'b0;
                rr_ptr <= win_nxt;
            end else begin
                locked <= 1'b1;
                owner  <= win;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

module noc_xbar_switch #(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = 16,
    parameter int DEST_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_PORTS*FLIT_W-1:0]   in_flit_i,
    input  logic [NUM_PORTS*DEST_W-1:0]   in_dest_i,
    input  logic [NUM_PORTS-1:0]          in_tail_i,
    input  logic [NUM_PORTS-1:0]          in_valid_i,
    output logic [NUM_PORTS-1:0]          in_ready_o,
    output logic [NUM_PORTS*FLIT_W-1:0]   out_flit_o,
    output logic [NUM_PORTS-1:0]          out_tail_o,
    output logic [NUM_PORTS-1:0]          out_valid_o,
    input  logic [NUM_PORTS-1:0]          out_ready_i,
    output logic [7:0]                    drop_cnt_o
);
    localparam int              PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [DEST_W:0] NP = (DEST_W + 1)'(NUM_PORTS);

    logic [NUM_PORTS-1:0][FLIT_W-1:0]    in_flit, out_flit;
    logic [NUM_PORTS-1:0][DEST_W-1:0]    in_dest;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req, gnt;
    logic [NUM_PORTS-1:0][PW-1:0]        owner;
    logic [NUM_PORTS-1:0]                locked, in_lock_any, drop_lock, drop_take, gnt_any;
    logic [8:0]                          drop_sum;

    assign in_flit    = in_flit_i;
    assign in_dest    = in_dest_i;
    assign out_flit_o = out_flit;

    always_comb begin
        in_lock_any = '0;
        for (int o = 0; o < NUM_PORTS; o++)
            if (locked[o]) in_lock_any[owner[o]] = 1'b1;
    end

    // A drop-state input and an output-locked input are mutually exclusive.
    always_comb begin
        req       = '0;
        drop_take = '0;
        for (int k = 0; k < NUM_PORTS; k++)
            drop_take[k] = in_valid_i[k] &&
                (drop_lock[k] || (!in_lock_any[k] && ({1'b0, in_dest[k]} >= NP)));
        for (int o = 0; o < NUM_PORTS; o++)
            for (int k = 0; k < NUM_PORTS; k++)
                req[o][k] = in_valid_i[k] && !drop_lock[k] &&
                    (locked[o] ? (owner[o] == PW'(k))
                               : (!in_lock_any[k] && in_dest[k] == DEST_W'(o)));
    end

    always_comb begin
        gnt_any = '0;
        for (int o = 0; o < NUM_PORTS; o++) gnt_any = gnt_any | gnt[o];
    end

    assign in_ready_o = rst_n_i ? (gnt_any | drop_take) : '0;

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_port
        noc_xbar_out_port #(.NUM_PORTS(NUM_PORTS), .FLIT_W(FLIT_W), .PW(PW)) u_port (
            .clk       (clk_i),
            .rst_n     (rst_n_i),
            .req       (req[o]),
            .in_flit   (in_flit),
            .in_tail   (in_tail_i),
            .out_ready (out_ready_i[o]),
            .gnt       (gnt[o]),
            .locked    (locked[o]),
            .owner     (owner[o]),
            .out_flit  (out_flit[o]),
            .out_tail  (out_tail_o[o]),
            .out_valid (out_valid_o[o])
        );
    end

    always_comb begin
        drop_sum = {1'b0, drop_cnt_o};
        for (int k = 0; k < NUM_PORTS; k++) drop_sum = drop_sum + 9'(drop_take[k]);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_lock  <= '0;
            drop_cnt_o <= '0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++)
                if (drop_take[k]) drop_lock[k] <= !in_tail_i[k];
            drop_cnt_o <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        end
    end
endmodule

// File: tb/tb_noc_xbar_switch.sv
// Randomised and directed bench for noc_xbar_switch against a cycle-level packet model.
module tb_noc_xbar_switch;
    localparam int N  = 5;
    localparam int FW = 16;
    localparam int DW = 3;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic [N*FW-1:0] in_flit;
    logic [N*DW-1:0] in_dest;
    logic [N-1:0]    in_tail, in_valid, in_ready, out_tail, out_valid, out_ready;
    logic [N*FW-1:0] out_flit;
    logic [7:0]      drop_cnt;

    noc_xbar_switch #(.NUM_PORTS(N), .FLIT_W(FW), .DEST_W(DW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .in_flit_i(in_flit), .in_dest_i(in_dest),
        .in_tail_i(in_tail), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_flit_o(out_flit), .out_tail_o(out_tail), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .drop_cnt_o(drop_cnt)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: per output an owner (-1 = free), RR start, and the held flit.
    int            m_lock[N], m_rr[N], m_win[N];
    bit            m_ov[N], m_ot[N], m_ld[N], m_drop[N], m_dt[N];
    logic [FW-1:0] m_of[N];
    int            m_cnt;
    logic [N-1:0]  m_rdy, last_rdy;

    function automatic int dst(input int k);
        return int'(in_dest[k*DW +: DW]);
    endfunction

    function automatic int lock_of(input int k);
        for (int o = 0; o < N; o++) if (m_lock[o] == k) return o;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_lock[i] = -1; m_rr[i] = 0; m_ov[i] = 0; m_ot[i] = 0; m_of[i] = '0; m_drop[i] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic model_comb();
        m_rdy = '0;
        for (int k = 0; k < N; k++) begin
            m_dt[k] = in_valid[k] && (m_drop[k] || (lock_of(k) < 0 && dst(k) >= N));
            if (m_dt[k]) m_rdy[k] = 1'b1;
        end
        for (int o = 0; o < N; o++) begin
            m_win[o] = -1;
            m_ld[o]  = !m_ov[o] || out_ready[o];
            if (m_lock[o] >= 0) begin
                if (in_valid[m_lock[o]]) m_win[o] = m_lock[o];
            end else begin
                for (int i = 0; i < N; i++) begin
                    int k;
                    k = (m_rr[o] + i) % N;
                    if (m_win[o] < 0 && in_valid[k] && !m_drop[k] && lock_of(k) < 0 && dst(k) == o)
                        m_win[o] = k;
                end
            end
            if (m_win[o] >= 0 && m_ld[o]) m_rdy[m_win[o]] = 1'b1;
        end
    endtask

    task automatic model_commit();
        for (int o = 0; o < N; o++) begin
            if (m_win[o] >= 0 && m_ld[o]) begin
                int k;
                k = m_win[o];
                m_ov[o] = 1; m_of[o] = in_flit[k*FW +: FW]; m_ot[o] = in_tail[k];
                if (in_tail[k]) begin m_lock[o] = -1; m_rr[o] = (k + 1) % N; end
                else m_lock[o] = k;
            end else if (out_ready[o]) m_ov[o] = 0;
        end
        for (int k = 0; k < N; k++)
            if (m_dt[k]) begin
                m_drop[k] = !in_tail[k];
                if (m_cnt < 255) m_cnt++;
            end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        logic [N-1:0] ev;
        #1;
        model_comb();
        last_rdy = in_ready;
        chk("in_ready", in_ready, m_rdy);
        @(posedge clk_i);
        model_commit();
        @(negedge clk_i);
        ev = '0;
        for (int o = 0; o < N; o++) ev[o] = m_ov[o];
        chk("out_valid", out_valid, ev);
        for (int o = 0; o < N; o++)
            if (m_ov[o]) begin
                chk("out_flit", out_flit[o*FW +: FW], m_of[o]);
                chk("out_tail", out_tail[o], m_ot[o]);
            end
        chk("drop_cnt", drop_cnt, m_cnt);
    endtask

    task automatic put(input int k, input bit v, input int d, input bit t, input logic [FW-1:0] f);
        in_valid[k] = v;
        in_dest[k*DW +: DW] = DW'(d);
        in_tail[k] = t;
        in_flit[k*FW +: FW] = f;
    endtask

    initial begin
        rst_n_i = 1'b0; in_flit = '0; in_dest = '0; in_tail = '0;
        in_valid = '1; out_ready = '1;
        model_reset();
        @(negedge clk_i); @(negedge clk_i);
        chk("rst_valid", out_valid, '0);
        chk("rst_flit", out_flit, '0);
        chk("rst_tail", out_tail, '0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_ready", in_ready, '0);
        rst_n_i = 1'b1; in_valid = '0;

        // single flit to out2
        put(0, 1, 2, 1, 16'hA5A5);
        step();
        chk("sf_ready", last_rdy, 5'b00001);
        chk("sf_flit", out_flit[2*FW +: FW], 16'hA5A5);
        chk("sf_valid", out_valid[2], 1'b1);

        // contention on out4 from inputs 0,1,3
        in_valid = '0;
        put(0, 1, 4, 1, 16'h0000); put(1, 1, 4, 1, 16'h0001); put(3, 1, 4, 1, 16'h0003);
        begin
            int order[4] = '{0, 1, 3, 0};
            for (int c = 0; c < 4; c++) begin
                step();
                chk("rr_ready", last_rdy, N'(1) << order[c]);
                chk("rr_flit", out_flit[4*FW +: FW], FW'(order[c]));
            end
        end

        // wormhole: in1 3-flit to out0 with a bubble, in2 waiting
        in_valid = '0;
        put(1, 1, 0, 0, 16'h1100); step(); chk("wh_head", last_rdy, 5'b00010);
        put(1, 0, 0, 0, 16'h0); put(2, 1, 0, 1, 16'h2200);
        step(); chk("wh_bubble", last_rdy, 5'b00000);
        put(1, 1, 3, 0, 16'h1101); step(); chk("wh_body", last_rdy, 5'b00010);
        chk("wh_body_flit", out_flit[0 +: FW], 16'h1101);
        put(1, 1, 2, 1, 16'h1102); step(); chk("wh_tail", last_rdy, 5'b00010);
        put(1, 0, 0, 0, 16'h0); step(); chk("wh_next", last_rdy, 5'b00100);
        chk("wh_next_flit", out_flit[0 +: FW], 16'h2200);

        // backpressure on out3
        in_valid = '0;
        put(0, 1, 3, 1, 16'h1234); step();
        put(0, 1, 3, 1, 16'h5678); out_ready[3] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("bp_ready", last_rdy[0], 1'b0);
            chk("bp_hold", out_flit[3*FW +: FW], 16'h1234);
        end
        out_ready = '1; step();
        chk("bp_rel_ready", last_rdy[0], 1'b1);
        chk("bp_rel_flit", out_flit[3*FW +: FW], 16'h5678);
        in_valid = '0; step();
        chk("bp_drain", out_valid, '0);

        // bad destination, 2-flit packet on in4
        put(4, 1, 7, 0, 16'hBAD0); step(); chk("bad_head", last_rdy, 5'b10000);
        put(4, 1, 2, 1, 16'hBAD1); step(); chk("bad_tail", last_rdy, 5'b10000);
        chk("bad_cnt", drop_cnt, 8'd2);
        chk("bad_novalid", out_valid, '0);

        // reset after head of a 4-flit packet
        in_valid = '0;
        put(0, 1, 1, 0, 16'hC000); step();
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, '0);
        chk("mid_rst_ready", in_ready, '0);
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        put(0, 1, 3, 0, 16'hC001); put(2, 1, 1, 1, 16'h2222);
        step();
        chk("mid_new_ready", last_rdy, 5'b00101);
        chk("mid_new_flit", out_flit[1*FW +: FW], 16'h2222);

        // random traffic
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N; k++)
                put(k, ($urandom % 10) < 7,
                    (($urandom % 16) < 14) ? int'($urandom % N) : int'(5 + $urandom % 3),
                    ($urandom % 5) < 2, FW'($urandom));
            for (int o = 0; o < N; o++) out_ready[o] = ($urandom % 4) != 0;
            step();
        end

        // saturate the drop counter
        out_ready = '1;
        for (int c = 0; c < 60; c++) begin
            for (int k = 0; k < N; k++) put(k, 1, 7, 1, FW'($urandom));
            step();
        end
        chk("drop_sat", drop_cnt, 8'd255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
